// File: rtl/stub_playback_gen_if.sv
// stub_playback_gen_if: control, pattern-write and replay-output signals of
// the stub playback generator. The master side drives the control and write
// signals, and the slave side (the generator) drives the replay outputs.
interface stub_playback_gen_if #(
  parameter int NCH        = 6,
  parameter int CH_BITS    = 3,
  parameter int WIDTH      = 36,
  parameter int DEPTH_LOG2 = 8
);

  logic                    BC0;
  logic                    enable;
  logic                    wr_en;
  logic [CH_BITS-1:0]      wr_ch;
  logic [DEPTH_LOG2-1:0]   wr_addr;
  logic [WIDTH:0]          wr_data;

  logic [NCH*WIDTH-1:0]    data_out;
  logic [NCH-1:0]          valid_out;
  logic [2:0]              bx_out;
  logic                    first_out;
  logic                    busy;
  logic                    done;

  modport master (
    output BC0, enable, wr_en, wr_ch, wr_addr, wr_data,
    input  data_out, valid_out, bx_out, first_out, busy, done
  );

  modport slave (
    input  BC0, enable, wr_en, wr_ch, wr_addr, wr_data,
    output data_out, valid_out, bx_out, first_out, busy, done
  );

endinterface

// File: rtl/stub_playback_gen.sv
// stub_playback_gen: multi-channel pattern replay source.
// Each channel owns a simple dual-port pattern RAM. A single shared write port
// selects the target RAM with wr_ch. All read ports share one play pointer.
// Playback is armed by enable and starts on BC0. It produces fixed-length
// events through a two-stage read pipeline.
// Optional build macro PLAYBACK_LOOP_EN: when it is defined, replay wraps
// continuously and never reaches DONE. When it is undefined, one pass of the
// whole RAM is emitted per arm.
module stub_playback_gen #(
  parameter int NCH        = 6,
  parameter int CH_BITS    = 3,
  parameter int WIDTH      = 36,
  parameter int DEPTH_LOG2 = 8,
  parameter int EVLEN_LOG2 = 5
) (
  input logic              clk,
  input logic              reset,
  stub_playback_gen_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef PLAYBACK_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_PLAY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [DEPTH_LOG2-1:0] addr_next;
  logic [2:0]            bx;
  logic                  stop_pending;
  logic                  busy_r;
  logic                  done_r;
  logic                  ev_end;
  logic                  last_addr;

  // Read-pipeline stage 1 sideband, aligned with the registered RAM output.
  logic                  v1;
  logic                  first1;
  logic [2:0]            bx1;
  logic [WIDTH:0]        ram_rd [NCH];

  // Output register stage.
  logic [NCH*WIDTH-1:0]  data_r;
  logic [NCH-1:0]        valid_r;
  logic [2:0]            bx_r;
  logic                  first_r;

  assign addr_next = rd_addr + 1'b1;
  assign ev_end    = &rd_addr[EVLEN_LOG2-1:0];
  assign last_addr = &rd_addr;

  // Per-channel pattern RAMs. Contents are never reset. A read on the same
  // edge as a write to the same address returns the previous word.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [WIDTH:0] mem [DEPTH];
    logic [WIDTH:0] q;

    // Shared write port, decoded by channel select; selects >= NCH match nothing
    always_ff @(posedge clk) begin
      if (bus.wr_en && (bus.wr_ch == CH_BITS'(k))) begin
        mem[bus.wr_addr] <= bus.wr_data;
      end
    end

    // Registered read at the common play pointer
    always_ff @(posedge clk) begin
      q <= mem[rd_addr];
    end

    assign ram_rd[k] = q;
  end

  // Playback FSM: owns the play pointer, event counter and registered busy/done
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      rd_addr      <= '0;
      bx           <= '0;
      stop_pending <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.enable) begin
            state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (!bus.enable) begin
            state <= S_IDLE;
          end else if (bus.BC0) begin
            state        <= S_PLAY;
            rd_addr      <= '0;
            bx           <= '0;
            stop_pending <= 1'b0;
            busy_r       <= 1'b1;
          end
        end
        S_PLAY: begin
          if (bus.BC0) begin
            rd_addr      <= '0;
            bx           <= '0;
            stop_pending <= stop_pending | ~bus.enable;
          end else if (ev_end && (stop_pending || !bus.enable)) begin
            state        <= S_IDLE;
            busy_r       <= 1'b0;
            stop_pending <= 1'b0;
          end else if (last_addr && !LOOP_EN) begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            rd_addr <= addr_next;
            if (addr_next[EVLEN_LOG2-1:0] == '0) begin
              bx <= bx + 1'b1;
            end
            if (!bus.enable) begin
              stop_pending <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!bus.enable) begin
            state  <= S_IDLE;
            done_r <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Stage 1: tag the RAM read issued this cycle with its valid, first and event number
  always_ff @(posedge clk) begin
    if (!reset) begin
      v1     <= 1'b0;
      first1 <= 1'b0;
      bx1    <= '0;
    end else begin
      v1     <= (state == S_PLAY);
      first1 <= (rd_addr[EVLEN_LOG2-1:0] == '0);
      bx1    <= bx;
    end
  end

  // Stage 2: output register; lanes without a valid stored word are forced to zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_r  <= '0;
      valid_r <= '0;
      bx_r    <= '0;
      first_r <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        valid_r[k]               <= v1 & ram_rd[k][WIDTH];
        data_r[k*WIDTH +: WIDTH] <= (v1 & ram_rd[k][WIDTH]) ? ram_rd[k][WIDTH-1:0] : '0;
      end
      bx_r    <= v1 ? bx1 : 3'd0;
      first_r <= v1 & first1;
    end
  end

  assign bus.data_out  = data_r;
  assign bus.valid_out = valid_r;
  assign bus.bx_out    = bx_r;
  assign bus.first_out = first_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_stub_playback_gen.sv
// tb_stub_playback_gen: randomized self-checking bench for stub_playback_gen.
// The reference model keeps its own copy of every pattern RAM. It predicts the
// replay as a list of play positions. Each position maps to a RAM address, an
// event number and a first-word flag.
module tb_stub_playback_gen;

  localparam int NCH        = 6;
  localparam int CH_BITS    = 3;
  localparam int WIDTH      = 36;
  localparam int DEPTH_LOG2 = 8;
  localparam int EVLEN_LOG2 = 5;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int EVLEN      = 1 << EVLEN_LOG2;
  localparam int MAXC       = 700;

`ifdef PLAYBACK_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef struct packed {
    logic                 word;
    logic [NCH*WIDTH-1:0] data;
    logic [NCH-1:0]       valid;
    logic [2:0]           bx;
    logic                 first;
    logic                 busy;
  } exp_t;

  typedef int pos_q_t [$];

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  stub_playback_gen_if #(.NCH(NCH), .CH_BITS(CH_BITS), .WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  stub_playback_gen #(
    .NCH(NCH), .CH_BITS(CH_BITS), .WIDTH(WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2), .EVLEN_LOG2(EVLEN_LOG2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH:0]       ref_mem   [NCH][DEPTH];
  logic [NCH*WIDTH-1:0] obs_data  [MAXC];
  logic [NCH-1:0]       obs_valid [MAXC];
  logic [2:0]           obs_bx    [MAXC];
  logic                 obs_first [MAXC];
  logic                 obs_busy  [MAXC];
  logic                 obs_done  [MAXC];

  // Sequence of play positions issued after BC0 at cycle 0. A resync restarts the
  // position at 0. A dropped enable stops at the end of the current event, and a
  // non-looping build stops after the last RAM word.
  function automatic pos_q_t issue_plan(input int bc0_at, input int drop_at, input int rst_at);
    pos_q_t q;
    int     p = 0;
    bit     dropped = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      q.push_back(p);
      if (c == rst_at) break;
      if (c == drop_at) dropped = 1'b1;
      if (c == bc0_at) begin
        p = 0;
        continue;
      end
      if (dropped && (p % EVLEN) == EVLEN - 1) break;
      if (!LOOP && p == DEPTH - 1) break;
      p++;
    end
    return q;
  endfunction

  // Expected outputs in observation cycle i. The word issued in cycle j shows
  // up in cycle j+2. A reset in cycle r wipes everything from cycle r+1 onward.
  function automatic exp_t expect_at(input pos_q_t q, input int i, input int rst_at);
    exp_t e;
    e = '0;
    e.busy = (i < q.size());
    if (i >= 2 && (i - 2) < q.size() && (rst_at < 0 || i <= rst_at)) begin
      int a;
      a       = q[i-2] % DEPTH;
      e.word  = 1'b1;
      e.bx    = 3'((q[i-2] / EVLEN) % 8);
      e.first = ((q[i-2] % EVLEN) == 0);
      for (int k = 0; k < NCH; k++) begin
        if (ref_mem[k][a][WIDTH]) begin
          e.valid[k]               = 1'b1;
          e.data[k*WIDTH +: WIDTH] = ref_mem[k][a][WIDTH-1:0];
        end
      end
    end
    return e;
  endfunction

  task automatic write_word(input int ch, input int addr, input logic [WIDTH:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = CH_BITS'(ch);
    bus.wr_addr = DEPTH_LOG2'(addr);
    bus.wr_data = data;
    if (ch < NCH) ref_mem[ch][addr] = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic load_patterns();
    logic [63:0] r;
    for (int ch = 0; ch < NCH; ch++) begin
      for (int a = 0; a < DEPTH; a++) begin
        r = {$urandom, $urandom};
        write_word(ch, a, {1'($urandom_range(0, 3) != 0), r[WIDTH-1:0]});
      end
    end
    for (int a = 0; a < 4; a++) write_word(0, a, {1'b1, 36'(a + 1)});
    write_word(3, 2, {1'b0, 36'hABCDE1234});
    for (int a = 0; a < 8; a++) write_word(6 + (a % 2), a, {1'b1, 36'hFFFFFFFFF});
  endtask

  task automatic arm();
    bus.enable = 1'b0;
    repeat (4) @(negedge clk);
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Pulses BC0 from ARMED, then records ncyc cycles of outputs starting with the
  // cycle right after the BC0 edge, applying the scheduled control events.
  task automatic run_capture(input int bc0_at, input int drop_at, input int rst_at,
                             input int wr_at, input int ncyc);
    @(negedge clk);
    bus.BC0 = 1'b1;
    @(negedge clk);
    bus.BC0 = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      obs_data[i]  = bus.data_out;
      obs_valid[i] = bus.valid_out;
      obs_bx[i]    = bus.bx_out;
      obs_first[i] = bus.first_out;
      obs_busy[i]  = bus.busy;
      obs_done[i]  = bus.done;
      bus.BC0      = (i == bc0_at);
      if (i == drop_at) bus.enable = 1'b0;
      reset        = (i == rst_at) ? 1'b0 : 1'b1;
      bus.wr_en    = (i == wr_at);
      @(negedge clk);
    end
    bus.BC0   = 1'b0;
    bus.wr_en = 1'b0;
    reset     = 1'b1;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    bus.BC0    = 1'b0;
    bus.enable = 1'b0;
    bus.wr_en  = 1'b0;
    bus.wr_ch  = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.data_out !== '0) begin n_fail++; $display("[TB] FAIL reset data_out: got %h, want 0", bus.data_out); end
    n_checks++;
    if (bus.valid_out !== '0) begin n_fail++; $display("[TB] FAIL reset valid_out: got %h, want 0", bus.valid_out); end
    n_checks++;
    if (bus.bx_out !== 3'd0) begin n_fail++; $display("[TB] FAIL reset bx_out: got %0d, want 0", bus.bx_out); end
    n_checks++;
    if (bus.first_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset first_out: got %b, want 0", bus.first_out); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset busy: got %b, want 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset done: got %b, want 0", bus.done); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_playback();
    int     drop = LOOP ? 560 : -1;
    int     nc;
    pos_q_t q;
    exp_t   e;
    logic   want_done;
    q  = issue_plan(-1, drop, -1);
    nc = q.size() + 6;
    arm();
    run_capture(-1, drop, -1, -1, nc);
    for (int i = 0; i < nc; i++) begin
      e = expect_at(q, i, -1);
      n_checks++;
      if (obs_valid[i] !== e.valid || obs_data[i] !== e.data || obs_first[i] !== e.first ||
          (e.word && obs_bx[i] !== e.bx)) begin
        n_fail++;
        $display("[TB] FAIL full_playback word @%0d: got v=%h f=%b bx=%0d d=%h, want v=%h f=%b bx=%0d d=%h",
                 i, obs_valid[i], obs_first[i], obs_bx[i], obs_data[i], e.valid, e.first, e.bx, e.data);
      end
      n_checks++;
      if (obs_busy[i] !== e.busy) begin
        n_fail++;
        $display("[TB] FAIL full_playback busy @%0d: got %b, want %b", i, obs_busy[i], e.busy);
      end
      want_done = !LOOP && (i >= q.size());
      n_checks++;
      if (obs_done[i] !== want_done) begin
        n_fail++;
        $display("[TB] FAIL full_playback done @%0d: got %b, want %b", i, obs_done[i], want_done);
      end
    end
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (obs_data[j+2][WIDTH-1:0] !== 36'(j + 1) || obs_valid[j+2][0] !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL first_words ch0 word %0d: got %h (v=%b), want %0d (v=1)",
                 j, obs_data[j+2][WIDTH-1:0], obs_valid[j+2][0], j + 1);
      end
    end
`ifndef PLAYBACK_LOOP_EN
    run_capture(-1, -1, -1, -1, 6);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (obs_valid[i] !== '0 || obs_data[i] !== '0 || obs_done[i] !== 1'b1 || obs_busy[i] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bc0_in_done @%0d: got v=%h done=%b busy=%b, want v=0 done=1 busy=0",
                 i, obs_valid[i], obs_done[i], obs_busy[i]);
      end
    end
`endif
  endtask

  task automatic test_resync();
    int     bc0 = 40;
    int     drop = 60 + int'($urandom_range(0, 20));
    int     nc;
    pos_q_t q;
    exp_t   e;
    q  = issue_plan(bc0, drop, -1);
    nc = q.size() + 6;
    arm();
    run_capture(bc0, drop, -1, -1, nc);
    for (int i = 0; i < nc; i++) begin
      e = expect_at(q, i, -1);
      n_checks++;
      if (obs_valid[i] !== e.valid || obs_data[i] !== e.data || obs_first[i] !== e.first ||
          (e.word && obs_bx[i] !== e.bx) || obs_busy[i] !== e.busy) begin
        n_fail++;
        $display("[TB] FAIL resync @%0d: got v=%h f=%b bx=%0d busy=%b d=%h, want v=%h f=%b bx=%0d busy=%b d=%h",
                 i, obs_valid[i], obs_first[i], obs_bx[i], obs_busy[i], obs_data[i],
                 e.valid, e.first, e.bx, e.busy, e.data);
      end
    end
  endtask

  task automatic test_enable_drop(input int drop);
    int     nc;
    pos_q_t q;
    exp_t   e;
    q  = issue_plan(-1, drop, -1);
    nc = q.size() + 6;
    arm();
    run_capture(-1, drop, -1, -1, nc);
    for (int i = 0; i < nc; i++) begin
      e = expect_at(q, i, -1);
      n_checks++;
      if (obs_valid[i] !== e.valid || obs_data[i] !== e.data || obs_first[i] !== e.first ||
          (e.word && obs_bx[i] !== e.bx) || obs_busy[i] !== e.busy) begin
        n_fail++;
        $display("[TB] FAIL enable_drop(%0d) @%0d: got v=%h f=%b bx=%0d busy=%b d=%h, want v=%h f=%b bx=%0d busy=%b d=%h",
                 drop, i, obs_valid[i], obs_first[i], obs_bx[i], obs_busy[i], obs_data[i],
                 e.valid, e.first, e.bx, e.busy, e.data);
      end
    end
  endtask

  task automatic test_bc0_enable_collide();
    int     c = 45 + int'($urandom_range(0, 30));
    int     nc;
    pos_q_t q;
    exp_t   e;
    q  = issue_plan(c, c, -1);
    nc = q.size() + 6;
    arm();
    run_capture(c, c, -1, -1, nc);
    for (int i = 0; i < nc; i++) begin
      e = expect_at(q, i, -1);
      n_checks++;
      if (obs_valid[i] !== e.valid || obs_data[i] !== e.data || obs_first[i] !== e.first ||
          (e.word && obs_bx[i] !== e.bx) || obs_busy[i] !== e.busy) begin
        n_fail++;
        $display("[TB] FAIL bc0_enable_collide @%0d: got v=%h f=%b bx=%0d busy=%b, want v=%h f=%b bx=%0d busy=%b",
                 i, obs_valid[i], obs_first[i], obs_bx[i], obs_busy[i], e.valid, e.first, e.bx, e.busy);
      end
    end
  endtask

  task automatic test_write_during_read();
    int             a = int'($urandom_range(3, 20));
    int             nc;
    logic [WIDTH:0] new_word;
    pos_q_t         q;
    exp_t           e;
    new_word    = {1'b1, ~ref_mem[2][a][WIDTH-1:0]};
    q           = issue_plan(-1, a + 1, -1);
    nc          = q.size() + 4;
    arm();
    bus.wr_ch   = CH_BITS'(2);
    bus.wr_addr = DEPTH_LOG2'(a);
    bus.wr_data = new_word;
    run_capture(-1, a + 1, -1, a, nc);
    for (int i = 0; i < nc; i++) begin
      e = expect_at(q, i, -1);
      n_checks++;
      if (obs_valid[i] !== e.valid || obs_data[i] !== e.data) begin
        n_fail++;
        $display("[TB] FAIL write_during_read @%0d: got v=%h d=%h, want v=%h d=%h",
                 i, obs_valid[i], obs_data[i], e.valid, e.data);
      end
    end
    ref_mem[2][a] = new_word;
  endtask

  task automatic test_reset_mid_play();
    int     r = int'($urandom_range(20, 100));
    int     nc;
    pos_q_t q;
    exp_t   e;
    q  = issue_plan(-1, -1, r);
    nc = r + 8;
    arm();
    run_capture(-1, -1, r, -1, nc);
    for (int i = 0; i < nc; i++) begin
      e = expect_at(q, i, r);
      n_checks++;
      if (obs_valid[i] !== e.valid || obs_data[i] !== e.data || obs_first[i] !== e.first ||
          (e.word && obs_bx[i] !== e.bx) || obs_busy[i] !== e.busy) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_play(%0d) @%0d: got v=%h f=%b bx=%0d busy=%b, want v=%h f=%b bx=%0d busy=%b",
                 r, i, obs_valid[i], obs_first[i], obs_bx[i], obs_busy[i], e.valid, e.first, e.bx, e.busy);
      end
    end
    n_checks++;
    if (obs_bx[r+1] !== 3'd0 || obs_done[r+1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_play clear: got bx=%0d done=%b, want bx=0 done=0", obs_bx[r+1], obs_done[r+1]);
    end
  endtask

  initial begin
    $display("[TB] stub_playback_gen bench start (loop build = %0b)", LOOP);
    test_reset();
    load_patterns();
    test_full_playback();
    test_enable_drop(10);
    test_resync();
    test_bc0_enable_collide();
    test_write_during_read();
    test_reset_mid_play();
    test_enable_drop(int'($urandom_range(5, 200)));
    test_full_playback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stub_playback_gen.md
# stub_playback_gen

Synthesizable multi-channel pattern replay source for the tracklet processing chain. It stores per-channel stub words loaded over a write port and replays them, aligned to the orbit marker `BC0`, as fixed-length events onto `NCH` parallel memory-style output channels. It supersedes file-driven stimulus with hardware-resident, parametrised playback, and can feed any processing module on-board or in simulation.

## Interface
Parameters:
- `NCH`, 6: number of output channels.
- `CH_BITS`, 3: width of channel select; 2^CH_BITS ≥ NCH.
- `WIDTH`, 36: data word width per channel.
- `DEPTH_LOG2`, 8: log2 of words stored per channel.
- `EVLEN_LOG2`, 5: log2 of cycles per event; NUM_EVENTS = 2^(DEPTH_LOG2−EVLEN_LOG2).

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-low.
- `BC0` in 1: orbit marker; start/resync pulse.
- `enable` in 1: arms playback.
- `wr_en` in 1: pattern RAM write strobe.
- `wr_ch` in CH_BITS: target channel; values ≥ NCH ignored.
- `wr_addr` in DEPTH_LOG2: word address.
- `wr_data` in WIDTH+1: bit WIDTH = word-valid flag, [WIDTH−1:0] = payload.
- `data_out` out NCH*WIDTH: channel k at [k*WIDTH +: WIDTH].
- `valid_out` out NCH: per-channel word valid.
- `bx_out` out 3: event number, wraps 7→0.
- `first_out` out 1: high on the first word cycle of each event.
- `busy` out 1: high in PLAY.
- `done` out 1: high in DONE.

## Operation
- Per channel: simple dual-port RAM, 2^DEPTH_LOG2 × (WIDTH+1). One write port is shared, decoded by `wr_ch`. The read port is common-addressed by the play pointer `rd_addr`.
- FSM states: IDLE, ARMED, PLAY, DONE.
  - IDLE→ARMED: `enable`=1.
  - ARMED→PLAY: `BC0`=1. `rd_addr`←0, `bx`←0.
  - ARMED→IDLE: `enable`=0.
  - PLAY: `rd_addr` increments each cycle. `bx` increments when `rd_addr[EVLEN_LOG2-1:0]` wraps to 0 (excluding the start cycle).
  - PLAY, `enable`=0: playback continues to the end of the current event, then goes to IDLE.
  - PLAY, last address (all ones): see Configuration.
  - PLAY, `BC0`=1: resync. `rd_addr`←0, `bx`←0, current event abandoned, `first_out` reasserted.
  - DONE→IDLE: `enable`=0. `BC0` is ignored in DONE.
- Output on each cycle: `valid_out[k]` = stored flag bit AND pipeline-stage-valid. `data_out` lane = payload when valid, else 0.
- Writes are allowed in every state. A same-cycle write and read of one address returns the old data.
- The RAM is not cleared by reset. Stored contents survive reset.
- Simultaneous `BC0` and `enable` falling in PLAY: resync wins for that cycle, then the enable-low rule applies.

## Timing
- Reset (`reset`=0 at a clk edge) takes effect at the next clock edge:
  - FSM goes to IDLE.
  - `data_out`, `valid_out`, `bx_out`, `first_out`, `busy`, `done` all 0.
  - In-flight pipeline stages invalidated.
- Read pipeline is 2 cycles: address register → RAM registered output → output register.
- `BC0` sampled in ARMED at edge T → word 0 on outputs after edge T+2, with `first_out`=1 and `bx_out`=0.
- Consecutive events are back-to-back with no gap cycles. `first_out` has period 2^EVLEN_LOG2.
- `busy` is registered from FSM state and leads the data by 2 cycles.
- `done` rises the cycle after the last address is issued. The final two words still drain after `done` rises.

## Configuration
- `PLAYBACK_LOOP_EN` defined:
  - At the last address, PLAY stays in PLAY with `rd_addr`←0.
  - Replay is continuous; `bx_out` keeps counting mod 8.
  - DONE is unreachable; `done` stays 0.
- `PLAYBACK_LOOP_EN` undefined:
  - At the last address, PLAY→DONE.
  - Exactly 2^DEPTH_LOG2 words are emitted per arm.
  - Re-arming requires `enable` to drop, then rise.

## Test plan
- Load ch0 addr0..3 = {1,0x000000001}…{1,0x000000004}, pulse `BC0` in ARMED at edge T → ch0 outputs 1,2,3,4 at edges T+2..T+5 with `first_out` at T+2, `bx_out`=0.
- Default parameters, loop undefined, enable held → 256 words, `first_out` pulses every 32 cycles, `bx_out` 0..7, `done`=1 after the last address; a second `BC0` produces no output.
- Loop defined → word 0 reappears 256 cycles after the first, `bx_out` goes 7→0 with no gap, `done` stays 0.
- `BC0` at play cycle 40 → outputs restart at word 0 two cycles later, `bx_out`=0, `first_out`=1.
- Drop `enable` at play cycle 10 → output continues through word 31, then `busy`=0 and `valid_out`=0.
- Assert `reset`=0 mid-play → all outputs 0 next cycle, state IDLE; re-arm plus `BC0` replays the previously loaded data unchanged. A word with its valid flag=0 gives `valid_out`=0 and `data_out` lane=0.
